acc8_2x1: RTL and testbench

ACC8_2X1 -- requirements
Module: acc8_2x1

---
 rtl/acc8_2x1_pkg.sv | 12 +
 rtl/mux8_2x1.sv | 26 ++
 rtl/acc8_2x1.sv | 101 ++++++++++
 tb/tb_acc8_2x1.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/acc8_2x1_pkg.sv
// Shared widths and state encodings for the acc8_2x1 frame accumulator.
package acc8_2x1_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage : acc8_2x1_pkg

// File: rtl/mux8_2x1.sv
// Gate-level 8-bit 2:1 mux: out = in1 when sel=1, in2 when sel=0.
module mux8_2x1
  import acc8_2x1_pkg::*;
(
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);

  wire              sel_n;
  wire [DATA_W-1:0] a_w;
  wire [DATA_W-1:0] b_w;
  wire [DATA_W-1:0] y_w;

  not u_inv (sel_n, sel);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    and u_and_a (a_w[i], in1[i], sel);
    and u_and_b (b_w[i], in2[i], sel_n);
    or  u_or    (y_w[i], a_w[i], b_w[i]);
  end

  assign out = y_w;

endmodule : mux8_2x1

// File: rtl/acc8_2x1.sv
// Frame accumulator: sums N selected 8-bit samples, holds the sum until the consumer takes it.
module acc8_2x1
  import acc8_2x1_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              carry,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_e              state_q;
  logic [DATA_W-1:0]   out_q;
  logic                carry_q;
  logic [CNT_W-1:0]    count_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [DATA_W-1:0]   sample_c;
  logic [DATA_W:0]     sum_c;
  logic [CNT_W-1:0]    count_inc_c;

  mux8_2x1 u_mux (
    .in1 (in1),
    .in2 (in2),
    .sel (sel),
    .out (sample_c)
  );

  // Extra MSB captures the carry-out of the 8-bit add.
  assign sum_c       = {1'b0, out_q} + {1'b0, sample_c};
  assign count_inc_c = count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      out_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= ST_ACC;
      out_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            out_q   <= sum_c[DATA_W-1:0];
            carry_q <= carry_q | sum_c[DATA_W];
            count_q <= count_inc_c;
            if (count_inc_c == N_CNT) begin
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Sample offered alongside out_ready is dropped: in_ready is low here.
          if (out_ready) begin
            state_q     <= ST_ACC;
            out_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign count     = count_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule : acc8_2x1

// File: tb/tb_acc8_2x1.sv
// Self-checking bench for acc8_2x1: N=4 and N=1 instances against a cycle model and frame scoreboard.
module tb_acc8_2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1, in2;
  logic       sel, in_valid, clr, out_ready;

  logic       in_ready4, out_valid4, carry4;
  logic [7:0] out4;
  logic [3:0] count4;
  logic       in_ready1, out_valid1, carry1;
  logic [7:0] out1;
  logic [3:0] count1;

  int n_checks = 0;
  int n_errors = 0;

  int         nval [2] = '{4, 1};
  logic [7:0] m_out [2];
  logic       m_carry [2];
  int         m_cnt [2];
  logic       m_done [2];
  logic       prev_ov [2];
  logic [8:0] sb4 [$];
  logic [8:0] sb1 [$];

  always #5 clk = ~clk;

  acc8_2x1 #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready4), .clr(clr),
    .out(out4), .out_valid(out_valid4), .out_ready(out_ready),
    .carry(carry4), .count(count4)
  );

  acc8_2x1 #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready1), .clr(clr),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
    .carry(carry1), .count(count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 8'h00; m_carry[k] = 1'b0; m_cnt[k] = 0;
      m_done[k] = 1'b0; prev_ov[k] = 1'b0;
    end
    sb4.delete();
    sb1.delete();
  endtask

  // Spec-level behaviour of one clock edge, from the inputs presented before it.
  task automatic model_edge();
    logic [8:0] s;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_out[k] = 8'h00; m_carry[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else if (!m_done[k]) begin
        if (in_valid) begin
          s = {1'b0, m_out[k]} + {1'b0, (sel ? in1 : in2)};
          m_out[k]   = s[7:0];
          m_carry[k] = m_carry[k] | s[8];
          m_cnt[k]++;
          if (m_cnt[k] == nval[k]) begin
            m_done[k] = 1'b1;
            if (k == 0) sb4.push_back({m_carry[k], m_out[k]});
            else        sb1.push_back({m_carry[k], m_out[k]});
          end
        end
      end else if (out_ready) begin
        m_out[k] = 8'h00; m_carry[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] o;
    logic [3:0] c;
    logic       cy, ov, ir;
    logic [8:0] e;
    string      p;
    for (int k = 0; k < 2; k++) begin
      o  = (k == 0) ? out4 : out1;
      c  = (k == 0) ? count4 : count1;
      cy = (k == 0) ? carry4 : carry1;
      ov = (k == 0) ? out_valid4 : out_valid1;
      ir = (k == 0) ? in_ready4 : in_ready1;
      p  = $sformatf("N%0d_", nval[k]);
      check({p, "out"}, o, m_out[k]);
      check({p, "count"}, c, m_cnt[k]);
      check({p, "carry"}, cy, m_carry[k]);
      check({p, "out_valid"}, ov, m_done[k]);
      check({p, "in_ready"}, ir, !m_done[k]);
      if (ov === 1'b1 && !prev_ov[k]) begin
        if ((k == 0 && sb4.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          check({p, "frame_unexpected"}, 1, 0);
        end else begin
          e = (k == 0) ? sb4.pop_front() : sb1.pop_front();
          check({p, "frame_sum"}, {cy, o}, e);
        end
      end
      prev_ov[k] = (ov === 1'b1);
    end
  endtask

  task automatic cycle(input logic iv, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic r);
    @(negedge clk);
    in_valid = iv; sel = s; in1 = a; in2 = b; clr = c; out_ready = r;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  // Release reset on a falling edge and present a sample for the very next rising edge.
  task automatic release_rst(input logic iv, input logic [7:0] a);
    @(negedge clk);
    rst = 1'b0; in_valid = iv; sel = 1'b1; in1 = a; in2 = 8'h00; clr = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_out", out4, 8'h00);
    check("async_rst_count", count4, 4'd0);
    check("async_rst_carry", carry4, 1'b0);
    check("async_rst_out_valid", out_valid4, 1'b0);
    check("async_rst_in_ready", in_ready4, 1'b1);
    compare_all();
    @(negedge clk);
    in_valid = 1'b1; sel = 1'b1; in1 = 8'h77;
    @(posedge clk);
    #1 compare_all();
  endtask

  initial begin
    rst = 1'b1; in1 = '0; in2 = '0; sel = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    #1 compare_all();

    // First accept on the first edge after release, then a mid-frame async reset.
    release_rst(1'b1, 8'h33);
    cycle(1, 1, 8'h33, 8'h00, 0, 0);
    check("pre_rst_count", count4, 4'd2);
    async_reset();
    release_rst(1'b0, 8'h00);

    // N=4, sel=1, in1=0x10 x4 -> 0x40, no carry.
    repeat (4) cycle(1, 1, 8'h10, 8'hFF, 0, 0);
    check("sum40_out", out4, 8'h40);
    check("sum40_valid", out_valid4, 1'b1);
    check("sum40_count", count4, 4'd4);

    // Backpressure: stay in DONE for 5 cycles while samples are offered.
    repeat (5) cycle(1, 1, 8'h55, 8'hAA, 0, 0);
    check("bp_out_stable", out4, 8'h40);
    cycle(1, 1, 8'h55, 8'hAA, 0, 1);
    check("bp_released_out", out4, 8'h00);

    // sel=0, in2=0x80 x4 -> wraps to 0x00 with sticky carry.
    repeat (4) cycle(1, 0, 8'h00, 8'h80, 0, 0);
    check("wrap_out", out4, 8'h00);
    check("wrap_carry", carry4, 1'b1);
    cycle(0, 0, 8'h00, 8'h00, 0, 1);

    // Alternating sources: 1+2+1+2 = 6.
    for (int i = 0; i < 4; i++) cycle(1, (i % 2) == 0, 8'h01, 8'h02, 0, 0);
    check("alt_out", out4, 8'h06);
    cycle(0, 0, 8'h00, 8'h00, 0, 1);

    // clr after 2 accepts wins over the sample offered with it.
    cycle(0, 0, 8'h00, 8'h00, 1, 0);
    repeat (2) cycle(1, 1, 8'h05, 8'h00, 0, 0);
    cycle(1, 1, 8'h05, 8'h00, 1, 0);
    check("clr_count", count4, 4'd0);
    repeat (4) cycle(1, 1, 8'h05, 8'h00, 0, 0);
    check("clr_frame_out", out4, 8'h14);
    cycle(0, 0, 8'h00, 8'h00, 1, 0);

    // N=1: out_ready with in_valid drops that sample, next cycle takes it.
    cycle(1, 1, 8'hFF, 8'h00, 0, 0);
    check("n1_out", out1, 8'hFF);
    check("n1_valid", out_valid1, 1'b1);
    cycle(1, 1, 8'hFF, 8'h00, 0, 1);
    check("n1_dropped", out1, 8'h00);
    cycle(1, 1, 8'hFF, 8'h00, 0, 0);
    check("n1_taken", out1, 8'hFF);
    cycle(0, 0, 8'h00, 8'h00, 1, 0);

    // Random traffic with occasional clr.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_acc8_2x1
